// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with valid/ready output and error status
`timescale 1ns/1ps

module uart_rx_cfg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int N    = CLK_FREQ / BAUD_RATE;
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(N);

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] N_M1      = CW'(N - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || N < 4) begin : g_param_err
    $error("uart_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q;
  logic                   rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0]          cnt_q;
  logic [3:0]             bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_err_q, fe_acc_q;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, frame_err_q, parity_err_q, overrun_q;

  logic [CW-1:0] cnt_tgt;
  logic          tick;
  logic          stop_fe;
  logic          drop;

  always_comb begin
    cnt_tgt = (state_q == START) ? HALF_M1 : N_M1;
    tick    = (cnt_q == cnt_tgt);
    stop_fe = fe_acc_q | ~rx_s_q;
    drop    = valid_q & ~ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      fe_acc_q     <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;

      if (state_q == IDLE || tick) cnt_q <= '0;
      else                         cnt_q <= cnt_q + 1'b1;

      // A completion in the same cycle overrides this consume below.
      if (valid_q && ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_en && rx_prev_q && !rx_s_q) state_q <= START;
        end
        START: begin
          if (tick) begin
            if (rx_s_q) state_q <= IDLE;
            else begin
              state_q <= DATA;
              bit_q   <= '0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_q    <= '0;
              fe_acc_q <= 1'b0;
              state_q  <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            par_err_q <= (PARITY == 1) ? ~((^shift_q) ^ rx_s_q) : ((^shift_q) ^ rx_s_q);
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            fe_acc_q <= stop_fe;
            if (bit_q == LAST_STOP) begin
              state_q <= IDLE;
              bit_q   <= '0;
              if (!drop) begin
                data_q       <= shift_q;
                frame_err_q  <= stop_fe;
                parity_err_q <= (PARITY != 0) ? par_err_q : 1'b0;
                valid_q      <= 1'b1;
                overrun_q    <= 1'b0;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg in 8N1, 7E1 and 8N2 builds
`timescale 1ns/1ps

module tb_uart_rx_cfg;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int N        = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx_en;
  logic rx_a, ready_a, valid_a, fe_a, pe_a, ov_a, busy_a;
  logic rx_p, ready_p, valid_p, fe_p, pe_p, ov_p, busy_p;
  logic rx_s, ready_s, valid_s, fe_s, pe_s, ov_s, busy_s;
  logic [7:0] data_a, data_s;
  logic [6:0] data_p;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_p (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx_p), .data(data_p), .valid(valid_p),
    .ready(ready_p), .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p), .busy(busy_p));
  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx_s), .data(data_s), .valid(valid_s),
    .ready(ready_s), .frame_err(fe_s), .parity_err(pe_s), .overrun(ov_s), .busy(busy_s));

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } rec_t;

  rec_t cap_a[$], cap_p[$], cap_s[$], exp_q[$];
  int   cyc = 0;
  int   errors = 0, checks = 0;
  int   fall_a = 0;
  logic pv_a = 1'b0, pv_p = 1'b0, pv_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture each rising edge of valid together with the payload seen on it.
  always @(negedge clk) begin
    if (valid_a && !pv_a) cap_a.push_back('{cyc, 9'(data_a), fe_a, pe_a, ov_a});
    if (!valid_a && pv_a) fall_a = cyc;
    if (valid_p && !pv_p) cap_p.push_back('{cyc, 9'(data_p), fe_p, pe_p, ov_p});
    if (valid_s && !pv_s) cap_s.push_back('{cyc, 9'(data_s), fe_s, pe_s, ov_s});
    pv_a = valid_a;
    pv_p = valid_p;
    pv_s = valid_s;
  end

  task automatic set_rx(input int inst, input logic b);
    if (inst == 0) rx_a = b;
    else if (inst == 1) rx_p = b;
    else rx_s = b;
  endtask

  task automatic send_frame(input int inst, input logic [8:0] d, input int nb, input bit has_par,
                            input bit pbit, input int nstop, input bit stop_v, output int start);
    @(negedge clk);
    start = cyc;
    set_rx(inst, 1'b0);
    repeat (N) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      set_rx(inst, d[i]);
      repeat (N) @(negedge clk);
    end
    if (has_par) begin
      set_rx(inst, pbit);
      repeat (N) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(inst, stop_v);
      repeat (N) @(negedge clk);
    end
    set_rx(inst, 1'b1);
  endtask

  task automatic get_rec(input int inst, input int budget, output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '{default: '0};
    for (int i = 0; i < budget && !ok; i++) begin
      if (inst == 0 && cap_a.size() > 0) begin r = cap_a.pop_front(); ok = 1'b1; end
      else if (inst == 1 && cap_p.size() > 0) begin r = cap_p.pop_front(); ok = 1'b1; end
      else if (inst == 2 && cap_s.size() > 0) begin r = cap_s.pop_front(); ok = 1'b1; end
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_a, fe_a, pe_a, ov_a, busy_a} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {valid_a, fe_a, pe_a, ov_a, busy_a});
    end
    checks++;
    if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
    checks++;
    if ({valid_s, busy_s, valid_p, busy_p} !== 4'b0) begin
      errors++; $display("FAIL reset_others: got %b want 0000", {valid_s, busy_s, valid_p, busy_p});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_8n1;
    rec_t r, e;
    bit   ok;
    int   st;
    exp_q.push_back('{98, 9'h0A5, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, st);
    get_rec(0, 200, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL t1_timeout: got no frame want one frame"); end
    else begin
      checks += 4;
      if (r.data !== e.data) begin errors++; $display("FAIL t1_data: got %h want %h", r.data, e.data); end
      if (r.fe !== e.fe) begin errors++; $display("FAIL t1_fe: got %b want %b", r.fe, e.fe); end
      if (r.pe !== e.pe) begin errors++; $display("FAIL t1_pe: got %b want %b", r.pe, e.pe); end
      if (r.cyc - st !== e.cyc) begin errors++; $display("FAIL t1_latency: got %0d want %0d", r.cyc - st, e.cyc); end
      repeat (2) @(negedge clk);
      checks++;
      if (fall_a - r.cyc !== 1) begin errors++; $display("FAIL t1_valid_fall: got %0d want 1", fall_a - r.cyc); end
    end
  endtask

  task automatic test_parity;
    rec_t r, e;
    bit   ok;
    int   st;
    for (int k = 0; k < 2; k++) begin
      bit pbit = (k == 0);
      exp_q.push_back('{98, 9'h003, 1'b0, pbit, 1'b0});
      send_frame(1, 9'h003, 7, 1'b1, pbit, 1, 1'b1, st);
      get_rec(1, 200, r, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL t2_timeout_%0d: got no frame want one frame", k); end
      else begin
        checks += 4;
        if (r.data !== e.data) begin errors++; $display("FAIL t2_data_%0d: got %h want %h", k, r.data, e.data); end
        if (r.pe !== e.pe) begin errors++; $display("FAIL t2_pe_%0d: got %b want %b", k, r.pe, e.pe); end
        if (r.fe !== e.fe) begin errors++; $display("FAIL t2_fe_%0d: got %b want %b", k, r.fe, e.fe); end
        if (r.cyc - st !== e.cyc) begin errors++; $display("FAIL t2_latency_%0d: got %0d want %0d", k, r.cyc - st, e.cyc); end
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_frame_err;
    rec_t r, e;
    bit   ok;
    int   st;
    logic [8:0] d;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 9'h03C : 9'h055;
      exp_q.push_back('{98, d, (k == 0), 1'b0, 1'b0});
      send_frame(0, d, 8, 1'b0, 1'b0, 1, (k != 0), st);
      repeat (5) @(negedge clk);
      get_rec(0, 200, r, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL t3_timeout_%0d: got no frame want one frame", k); end
      else begin
        checks += 3;
        if (r.data !== e.data) begin errors++; $display("FAIL t3_data_%0d: got %h want %h", k, r.data, e.data); end
        if (r.fe !== e.fe) begin errors++; $display("FAIL t3_fe_%0d: got %b want %b", k, r.fe, e.fe); end
        if (r.pe !== e.pe) begin errors++; $display("FAIL t3_pe_%0d: got %b want %b", k, r.pe, e.pe); end
      end
    end
  endtask

  task automatic test_false_start;
    int bc = 0, run = 0, max_run = 0;
    int n0 = cap_a.size();
    rx_en = 1'b1;
    @(negedge clk);
    set_rx(0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 3) set_rx(0, 1'b1);
      @(negedge clk);
      if (busy_a) begin bc++; run++; if (run > max_run) max_run = run; end
      else run = 0;
    end
    checks += 4;
    if ((bc > 0) !== 1'b1) begin errors++; $display("FAIL t4_busy_rose: got %0d busy cycles want >0", bc); end
    if (max_run > 6) begin errors++; $display("FAIL t4_busy_len: got %0d want <=6", max_run); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL t4_busy_end: got %b want 0", busy_a); end
    if (cap_a.size() !== n0) begin errors++; $display("FAIL t4_no_valid: got %0d frames want %0d", cap_a.size(), n0); end
    rx_en = 1'b0;
    bc = 0;
    @(negedge clk);
    set_rx(0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (i == 3) set_rx(0, 1'b1);
      @(negedge clk);
      if (busy_a) bc++;
    end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL t4_disabled_busy: got %0d busy cycles want 0", bc); end
    rx_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun;
    rec_t r, e;
    bit   ok;
    int   st;
    ready_a = 1'b0;
    exp_q.push_back('{98, 9'h011, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, st);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, st);
    repeat (3) @(negedge clk);
    get_rec(0, 200, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_timeout: got no frame want one frame"); end
    else begin
      checks += 2;
      if (r.data !== e.data) begin errors++; $display("FAIL t5_first_data: got %h want %h", r.data, e.data); end
      if (r.ov !== e.ov) begin errors++; $display("FAIL t5_first_ov: got %b want %b", r.ov, e.ov); end
    end
    checks += 4;
    if (valid_a !== 1'b1) begin errors++; $display("FAIL t5_held_valid: got %b want 1", valid_a); end
    if (data_a !== 8'h11) begin errors++; $display("FAIL t5_held_data: got %h want 11", data_a); end
    if (ov_a !== 1'b1) begin errors++; $display("FAIL t5_overrun: got %b want 1", ov_a); end
    if (cap_a.size() !== 0) begin errors++; $display("FAIL t5_extra_frame: got %0d want 0", cap_a.size()); end
    ready_a = 1'b1;
    @(negedge clk);
    checks += 2;
    if (valid_a !== 1'b0) begin errors++; $display("FAIL t5_hs_valid: got %b want 0", valid_a); end
    if (ov_a !== 1'b0) begin errors++; $display("FAIL t5_hs_ov: got %b want 0", ov_a); end
    exp_q.push_back('{98, 9'h033, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1, 1'b1, st);
    get_rec(0, 200, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL t5_timeout2: got no frame want one frame"); end
    else begin
      checks += 2;
      if (r.data !== e.data) begin errors++; $display("FAIL t5_data2: got %h want %h", r.data, e.data); end
      if (r.ov !== e.ov) begin errors++; $display("FAIL t5_ov2: got %b want %b", r.ov, e.ov); end
    end
  endtask

  task automatic test_reset_mid;
    rec_t r, e;
    bit   ok;
    int   st, st2;
    ready_s = 1'b0;
    exp_q.push_back('{108, 9'h081, 1'b0, 1'b0, 1'b0});
    send_frame(2, 9'h081, 8, 1'b0, 1'b0, 2, 1'b1, st);
    get_rec(2, 200, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || r.data !== e.data) begin errors++; $display("FAIL t6_held_frame: got %h want %h", r.data, e.data); end
    repeat (3) @(negedge clk);
    fork
      send_frame(2, 9'h0FF, 8, 1'b0, 1'b0, 2, 1'b1, st2);
      begin
        repeat (44) @(negedge clk);
        checks += 2;
        if (busy_s !== 1'b1) begin errors++; $display("FAIL t6_busy_before: got %b want 1", busy_s); end
        if (valid_s !== 1'b1) begin errors++; $display("FAIL t6_valid_before: got %b want 1", valid_s); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if ({valid_s, fe_s, pe_s, ov_s, busy_s} !== 5'b0) begin
          errors++; $display("FAIL t6_reset_flags: got %b want 00000", {valid_s, fe_s, pe_s, ov_s, busy_s});
        end
        if (data_s !== 8'h00) begin errors++; $display("FAIL t6_reset_data: got %h want 00", data_s); end
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    checks++;
    if (cap_s.size() !== 0) begin errors++; $display("FAIL t6_aborted_frame: got %0d frames want 0", cap_s.size()); end
    ready_s = 1'b1;
    exp_q.push_back('{108, 9'h0F0, 1'b0, 1'b0, 1'b0});
    send_frame(2, 9'h0F0, 8, 1'b0, 1'b0, 2, 1'b1, st);
    get_rec(2, 200, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_timeout: got no frame want one frame"); end
    else begin
      checks += 3;
      if (r.data !== e.data) begin errors++; $display("FAIL t6_data: got %h want %h", r.data, e.data); end
      if (r.fe !== e.fe) begin errors++; $display("FAIL t6_fe: got %b want %b", r.fe, e.fe); end
      if (r.cyc - st !== e.cyc) begin errors++; $display("FAIL t6_latency: got %0d want %0d", r.cyc - st, e.cyc); end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_en   = 1'b1;
    rx_a    = 1'b1; rx_p = 1'b1; rx_s = 1'b1;
    ready_a = 1'b1; ready_p = 1'b1; ready_s = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
